// File: rtl/freq_meas_pkg.sv
// Shared types for the freq_meas slow-input period / high-time meter.
package freq_meas_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_MEAS = 1'b1
   } state_e;

   localparam int EDGE_W = 8;

endpackage

// File: rtl/freq_meas_sync_edge_det.sv
// Multi-stage synchronizer for an asynchronous slow input, followed by
// registered one-cycle rise/fall pulses. Reusable by any slow-input block.
module sync_edge_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_async,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_level_d;
   logic                   r_rise;
   logic                   r_fall;
   logic                   w_level;

   assign w_level = r_sync[SYNC_STAGES-1];

   // Pulses are registered so every consumer sees a glitch-free single-cycle strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync    <= '0;
         r_level_d <= 1'b0;
         r_rise    <= 1'b0;
         r_fall    <= 1'b0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], i_async};
         r_level_d <= w_level;
         r_rise    <= w_level & ~r_level_d;
         r_fall    <= ~w_level & r_level_d;
      end
   end

   assign o_rise = r_rise;
   assign o_fall = r_fall;

endmodule

// File: rtl/freq_meas.sv
// Measures period and high time of a slow asynchronous input in clk cycles,
// with an edge counter and a timeout flag when edges stop arriving.
module freq_meas
   import freq_meas_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sig_in,
   output logic [CNT_W-1:0]  period,
   output logic [CNT_W-1:0]  high_time,
   output logic              valid,
   output logic              timeout,
   output logic [EDGE_W-1:0] edge_cnt,
   output state_e            dbg_state
);

   localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
   localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
   localparam logic [EDGE_W-1:0] EDGE_ONE = EDGE_W'(1);

   logic              w_rise;
   logic              w_fall;
   logic              w_sat;
   logic              w_arm;
   logic              w_meas_done;
   logic              w_to_set;
   state_e            r_state;
   state_e            w_state_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CNT_W-1:0]  r_hi_lat;
   logic [CNT_W-1:0]  r_period;
   logic [CNT_W-1:0]  r_high_time;
   logic              r_valid;
   logic              r_timeout;
   logic [EDGE_W-1:0] r_edge_cnt;

   sync_edge_det #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync (
      .clk     (clk),
      .rst_n   (reset),
      .i_async (sig_in),
      .o_rise  (w_rise),
      .o_fall  (w_fall)
   );

   assign w_sat = (r_cnt == CNT_MAX);

   // A rise in the same cycle as saturation still closes the measurement.
   always_comb begin
      w_state_nxt = r_state;
      w_arm       = 1'b0;
      w_meas_done = 1'b0;
      w_to_set    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_rise) begin
               w_state_nxt = ST_MEAS;
               w_arm       = 1'b1;
            end
         end
         ST_MEAS: begin
            if (w_rise) begin
               w_meas_done = 1'b1;
            end else if (w_sat) begin
               w_state_nxt = ST_IDLE;
               w_to_set    = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Counter restarts at 1 on each rise so it equals the rise-to-rise spacing.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt    <= '0;
         r_hi_lat <= '0;
      end else begin
         if (w_rise) begin
            r_cnt <= CNT_ONE;
         end else if (!w_sat) begin
            r_cnt <= r_cnt + CNT_ONE;
         end
         if (w_fall && (r_state == ST_MEAS)) begin
            r_hi_lat <= r_cnt;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_period    <= '0;
         r_high_time <= '0;
         r_valid     <= 1'b0;
         r_timeout   <= 1'b0;
         r_edge_cnt  <= '0;
      end else begin
         r_valid <= w_meas_done;
         if (w_rise) begin
            r_edge_cnt <= r_edge_cnt + EDGE_ONE;
         end
         if (w_meas_done) begin
            r_period    <= r_cnt;
            r_high_time <= r_hi_lat;
         end
         if (w_arm) begin
            r_timeout <= 1'b0;
         end else if (w_to_set) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign period    = r_period;
   assign high_time = r_high_time;
   assign valid     = r_valid;
   assign timeout   = r_timeout;
   assign edge_cnt  = r_edge_cnt;
   assign dbg_state = r_state;

endmodule

// File: tb/tb_freq_meas.sv
// Directed bench for freq_meas: a 16-bit and an 8-bit instance share one
// stimulus; a background driver plays a square wave or a manual level.
module tb_freq_meas;
   import freq_meas_pkg::*;

   logic        clk;
   logic        reset;
   logic        sig_in;

   logic [15:0] p16, h16;
   logic        v16, t16;
   logic [7:0]  e16;
   state_e      s16;

   logic [7:0]  p8, h8;
   logic        v8, t8;
   logic [7:0]  e8;
   state_e      s8;

   logic        man_val;
   logic        gen_en;
   int          gen_hi;
   int          gen_lo;

   int          checks;
   int          failures;

   int          cyc;
   logic        ok;
   logic        seen10;
   logic        seen_v8;
   logic [7:0]  e_prev;

   freq_meas #(.CNT_W(16), .SYNC_STAGES(2)) dut16 (
      .clk       (clk),
      .reset     (reset),
      .sig_in    (sig_in),
      .period    (p16),
      .high_time (h16),
      .valid     (v16),
      .timeout   (t16),
      .edge_cnt  (e16),
      .dbg_state (s16)
   );

   freq_meas #(.CNT_W(8), .SYNC_STAGES(2)) dut8 (
      .clk       (clk),
      .reset     (reset),
      .sig_in    (sig_in),
      .period    (p8),
      .high_time (h8),
      .valid     (v8),
      .timeout   (t8),
      .edge_cnt  (e8),
      .dbg_state (s8)
   );

   // clock / reset block
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // sig_in driver: updates on negedge; new wave shape is taken at a period boundary
   initial begin
      int ph;
      int cur_hi;
      int cur_lo;
      ph     = 0;
      cur_hi = 3;
      cur_lo = 3;
      sig_in = 1'b0;
      forever begin
         @(negedge clk);
         if (!gen_en) begin
            sig_in = man_val;
            ph     = 0;
         end else begin
            if (ph == 0) begin
               cur_hi = gen_hi;
               cur_lo = gen_lo;
            end
            sig_in = (ph < cur_hi);
            ph     = (ph + 1 >= cur_hi + cur_lo) ? 0 : ph + 1;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic hold(input logic v, input int n);
      man_val = v;
      repeat (n) tick();
   endtask

   task automatic wait_valid(input int budget, output int n, output logic seen);
      n    = 0;
      seen = 1'b0;
      while (!seen && n < budget) begin
         tick();
         n++;
         seen = v16;
      end
   endtask

   task automatic do_reset();
      gen_en  = 1'b0;
      man_val = 1'b0;
      reset   = 1'b0;
      repeat (3) tick();
      reset   = 1'b1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      man_val  = 1'b0;
      gen_en   = 1'b0;
      gen_hi   = 3;
      gen_lo   = 3;

      // reset state
      repeat (2) tick();
      chk("rst_period",  p16, 0);
      chk("rst_high",    h16, 0);
      chk("rst_valid",   v16, 0);
      chk("rst_timeout", t16, 0);
      chk("rst_edges",   e16, 0);
      chk("rst_state",   s16, ST_IDLE);
      chk("rst_p8",      p8, 0);
      reset = 1'b1;
      tick();

      // divide-by-6 square wave: first valid only after the second rise
      gen_en = 1'b1;
      wait_valid(40, cyc, ok);
      chk("t1_found",     ok, 1);
      chk("t1_first_lat", cyc, 10);
      chk("t1_edges",     e16, 2);
      chk("t1_period",    p16, 6);
      chk("t1_high",      h16, 3);
      chk("t1_p8",        p8, 6);
      wait_valid(20, cyc, ok);
      chk("t1_spacing",   cyc, 6);
      chk("t1_period2",   p16, 6);
      chk("t1_high2",     h16, 3);
      chk("t1_edges2",    e16, 3);
      tick();
      chk("t1_pulse",     v16, 0);

      // one-cycle impulse every 5 clocks
      gen_hi = 1;
      gen_lo = 4;
      for (int i = 0; i < 4; i++) begin
         wait_valid(20, cyc, ok);
         if (!ok || p16 == 16'd5) break;
      end
      chk("t2_found",  ok, 1);
      chk("t2_period", p16, 5);
      chk("t2_high",   h16, 1);
      e_prev = e16;
      wait_valid(20, cyc, ok);
      chk("t2_spacing", cyc, 5);
      chk("t2_period2", p16, 5);
      chk("t2_high2",   h16, 1);
      chk("t2_edge_inc", e16, 32'(e_prev + 8'd1));

      // 8-bit instance: input stuck low after two edges
      do_reset();
      hold(1'b1, 3);
      hold(1'b0, 3);
      hold(1'b1, 3);
      man_val = 1'b0;
      wait_valid(10, cyc, ok);
      chk("t3_found",  ok, 1);
      chk("t3_lat",    cyc, 1);
      chk("t3_p8",     p8, 6);
      chk("t3_h8",     h8, 3);
      chk("t3_e8",     e8, 2);
      cyc = 0;
      while (!t8 && cyc < 300) begin
         tick();
         cyc++;
      end
      chk("t3_to_cycles", cyc, 255);
      chk("t3_timeout",   t8, 1);
      chk("t3_p8_hold",   p8, 6);
      chk("t3_h8_hold",   h8, 3);
      chk("t3_state8",    s8, ST_IDLE);
      chk("t3_t16",       t16, 0);
      chk("t3_state16",   s16, ST_MEAS);
      man_val = 1'b1;
      e_prev  = e8;
      seen_v8 = 1'b0;
      cyc     = 0;
      while (e8 == e_prev && cyc < 10) begin
         tick();
         cyc++;
         if (v8) seen_v8 = 1'b1;
      end
      chk("t3_rearm_e8",  e8, 3);
      chk("t3_to_clear",  t8, 0);
      chk("t3_no_valid8", seen_v8, 0);
      chk("t3_state8b",   s8, ST_MEAS);
      chk("t3_v16",       v16, 1);
      chk("t3_p16_long",  p16, 259);
      chk("t3_h16",       h16, 3);

      // reset asserted during a high phase, then the wave resumes
      hold(1'b0, 4);
      gen_hi = 3;
      gen_lo = 3;
      gen_en = 1'b1;
      wait_valid(40, cyc, ok);
      wait_valid(40, cyc, ok);
      chk("t4_pre_found", ok, 1);
      cyc = 0;
      while (!sig_in && cyc < 10) begin
         tick();
         cyc++;
      end
      chk("t4_sig_high", sig_in, 1);
      reset = 1'b0;
      #1;
      chk("t4_rst_p16", p16, 0);
      chk("t4_rst_h16", h16, 0);
      chk("t4_rst_e16", e16, 0);
      chk("t4_rst_st",  s16, ST_IDLE);
      chk("t4_rst_p8",  p8, 0);
      chk("t4_rst_e8",  e8, 0);
      repeat (2) tick();
      chk("t4_rst_v16", v16, 0);
      chk("t4_rst_t8",  t8, 0);
      cyc = 0;
      while (sig_in && cyc < 10) begin
         tick();
         cyc++;
      end
      reset = 1'b1;
      wait_valid(40, cyc, ok);
      chk("t4_found",  ok, 1);
      chk("t4_edges",  e16, 2);
      chk("t4_period", p16, 6);
      chk("t4_high",   h16, 3);

      // period change 6 -> 10 with high 5
      gen_hi = 5;
      gen_lo = 5;
      seen10 = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (!seen10) begin
            wait_valid(30, cyc, ok);
            chk("t5_found", ok, 1);
            chk("t5_no_glitch", ((p16 == 16'd6 && h16 == 16'd3) || (p16 == 16'd10 && h16 == 16'd5)), 1);
            if (p16 == 16'd10) seen10 = 1'b1;
         end
      end
      chk("t5_seen10", seen10, 1);
      wait_valid(30, cyc, ok);
      chk("t5_spacing", cyc, 10);
      chk("t5_period",  p16, 10);
      chk("t5_high",    h16, 5);

      // 300 rises: edge counter wraps; then edge-to-valid latency
      do_reset();
      for (int i = 0; i < 300; i++) begin
         hold(1'b1, 1);
         hold(1'b0, 2);
      end
      hold(1'b0, 6);
      chk("t6_e16",    e16, 44);
      chk("t6_e8",     e8, 44);
      chk("t6_period", p16, 3);
      chk("t6_high",   h16, 1);
      man_val = 1'b1;
      wait_valid(10, cyc, ok);
      chk("t6_found",   ok, 1);
      chk("t6_latency", cyc, 4);
      chk("t6_period2", p16, 9);
      chk("t6_high2",   h16, 1);
      chk("t6_e16b",    e16, 45);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
